// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with ghost-guard, leading-zero
// blanking, whole-display blink and a colon decimal point on digit 2.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 500,
    parameter int unsigned BLINK_SLOTS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        lz_en,
    input  logic        blink_en,
    input  logic        colon_en,
    output logic [3:0]  anode,
    output logic [3:0]  bcd_out,
    output logic        dp_n,
    output logic        slot_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_SLOTS - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      snap, snap_nxt;
    logic [BLK_W-1:0] bcnt, bcnt_nxt;
    logic             phase, phase_nxt;
    logic             wrap;

    logic [3:0] blank;
    logic [3:0] nib;
    logic       in_guard;
    logic       blink_off;
    logic [3:0] anode_nxt;
    logic [3:0] bcd_nxt;
    logic       dp_n_nxt;
    logic       tick_nxt;

    // Slot timing, digit index, frame snapshot and blink phase
    always_comb begin
        wrap      = (cnt == CNT_LAST);
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        snap_nxt  = snap;
        bcnt_nxt  = bcnt;
        phase_nxt = phase;
        if (wrap) begin
            cnt_nxt = '0;
            idx_nxt = idx + 2'd1;
            if (idx == 2'd3) begin
                snap_nxt = digits;
            end
            if (bcnt == BLK_LAST) begin
                bcnt_nxt  = '0;
                phase_nxt = ~phase;
            end else begin
                bcnt_nxt = bcnt + BLK_W'(1);
            end
        end
    end

    // Output decode from the post-edge state so outputs line up with the new slot
    always_comb begin
        blank     = '0;
        blank[3]  = lz_en && (snap_nxt[15:12] == 4'h0);
        blank[2]  = blank[3] && (snap_nxt[11:8] == 4'h0);
        blank[1]  = blank[2] && (snap_nxt[7:4] == 4'h0);

        nib = snap_nxt[3:0];
        case (idx_nxt)
            2'd0:    nib = snap_nxt[3:0];
            2'd1:    nib = snap_nxt[7:4];
            2'd2:    nib = snap_nxt[11:8];
            default: nib = snap_nxt[15:12];
        endcase

        in_guard  = (cnt_nxt < GUARD_END);
        blink_off = blink_en && phase_nxt;

        anode_nxt = 4'hF;
        if (!in_guard && !blink_off && !blank[idx_nxt]) begin
            anode_nxt[idx_nxt] = 1'b0;
        end

        bcd_nxt  = blank[idx_nxt] ? 4'hF : nib;
        dp_n_nxt = !(colon_en && (idx_nxt == 2'd2) && !in_guard && !blink_off);
        tick_nxt = (cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            snap      <= 16'h0000;
            bcnt      <= '0;
            phase     <= 1'b0;
            anode     <= 4'hF;
            bcd_out   <= 4'hF;
            dp_n      <= 1'b1;
            slot_tick <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            snap      <= snap_nxt;
            bcnt      <= bcnt_nxt;
            phase     <= phase_nxt;
            anode     <= anode_nxt;
            bcd_out   <= bcd_nxt;
            dp_n      <= dp_n_nxt;
            slot_tick <= tick_nxt;
        end
    end

endmodule
